// File: rtl/apb_rw_scheduler_if.sv
// rtl/apb_rw_scheduler_if.sv - request/response FIFO and APB bus bundle for apb_rw_scheduler
// master: the scheduler side; slave: FIFOs plus APB completer side.
interface apb_rw_scheduler_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  wr_empty;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_strb;
  logic [2:0]            wr_prot;
  logic                  wr_pop;

  logic                  rd_empty;
  logic [ADDR_W-1:0]     rd_addr;
  logic [2:0]            rd_prot;
  logic                  rd_pop;

  logic                  b_full;
  logic                  b_push;
  logic [1:0]            b_resp;

  logic                  r_full;
  logic                  r_push;
  logic [DATA_W-1:0]     r_data;
  logic [1:0]            r_resp;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [2:0]            pprot;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  wr_empty, wr_addr, wr_data, wr_strb, wr_prot,
    output wr_pop,
    input  rd_empty, rd_addr, rd_prot,
    output rd_pop,
    input  b_full,
    output b_push, b_resp,
    input  r_full,
    output r_push, r_data, r_resp,
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    output wr_empty, wr_addr, wr_data, wr_strb, wr_prot,
    input  wr_pop,
    output rd_empty, rd_addr, rd_prot,
    input  rd_pop,
    output b_full,
    input  b_push, b_resp,
    output r_full,
    input  r_push, r_data, r_resp,
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_rw_scheduler.sv
// rtl/apb_rw_scheduler.sv - round-robin write/read sequencer for the APB master port of the AXI4-Lite bridge
// Optional ACCESS-phase timeout abort is enabled by defining APB_TIMEOUT_EN.
module apb_rw_scheduler #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic               clk,
  input  logic               rst,
  apb_rw_scheduler_if.master bus
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;
  typedef enum logic {GR_WRITE, GR_READ} grant_t;

  state_t     state;
  grant_t     last_grant;

  logic       wr_elig;
  logic       rd_elig;
  logic       complete;
  logic       abort_xfer;
  logic       resp_fire;
  logic       grant_any;
  logic       grant_wr;
  logic [1:0] resp_code;

  assign wr_elig  = ~bus.wr_empty & ~bus.b_full;
  assign rd_elig  = ~bus.rd_empty & ~bus.r_full;
  assign complete = (state == ST_ACCESS) & bus.pready;

`ifdef APB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;
  assign abort_xfer = (state == ST_ACCESS) & ~bus.pready & (tmo_cnt == TIMEOUT_LAST);
`else
  assign abort_xfer = 1'b0;
`endif

  // A grant can happen from IDLE or on the completing ACCESS cycle, never on an abort.
  assign grant_any = ((state == ST_IDLE) | complete) & (wr_elig | rd_elig);
  assign grant_wr  = wr_elig & (~rd_elig | (last_grant == GR_READ));

  assign bus.wr_pop = rst & grant_any & grant_wr;
  assign bus.rd_pop = rst & grant_any & ~grant_wr;

  assign resp_fire  = complete | abort_xfer;
  assign resp_code  = abort_xfer ? 2'b10 : {bus.pslverr, 1'b0};
  assign bus.b_push = resp_fire & bus.pwrite;
  assign bus.r_push = resp_fire & ~bus.pwrite;
  assign bus.b_resp = bus.b_push ? resp_code : 2'b00;
  assign bus.r_resp = bus.r_push ? resp_code : 2'b00;
  assign bus.r_data = (bus.r_push & ~abort_xfer) ? bus.prdata : {DATA_W{1'b0}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      last_grant  <= GR_READ;
      bus.psel    <= 1'b0;
      bus.penable <= 1'b0;
      bus.pwrite  <= 1'b0;
      bus.paddr   <= {ADDR_W{1'b0}};
      bus.pwdata  <= {DATA_W{1'b0}};
      bus.pstrb   <= {STRB_W{1'b0}};
      bus.pprot   <= 3'b000;
`ifdef APB_TIMEOUT_EN
      tmo_cnt     <= 16'd0;
`endif
    end else begin
      case (state)
        ST_SETUP: begin
          bus.penable <= 1'b1;
          state       <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (resp_fire) begin
            bus.psel    <= 1'b0;
            bus.penable <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: ;
      endcase

`ifdef APB_TIMEOUT_EN
      if (state == ST_SETUP) begin
        tmo_cnt <= 16'd0;
      end else if ((state == ST_ACCESS) && !bus.pready) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
`endif

      // Later assignment wins: a back-to-back grant overrides the ACCESS->IDLE drop.
      if (grant_any) begin
        bus.psel    <= 1'b1;
        bus.penable <= 1'b0;
        state       <= ST_SETUP;
        if (grant_wr) begin
          last_grant <= GR_WRITE;
          bus.pwrite <= 1'b1;
          bus.paddr  <= bus.wr_addr;
          bus.pwdata <= bus.wr_data;
          bus.pstrb  <= bus.wr_strb;
          bus.pprot  <= bus.wr_prot;
        end else begin
          last_grant <= GR_READ;
          bus.pwrite <= 1'b0;
          bus.paddr  <= bus.rd_addr;
          bus.pwdata <= {DATA_W{1'b0}};
          bus.pstrb  <= {STRB_W{1'b0}};
          bus.pprot  <= bus.rd_prot;
        end
      end
    end
  end
endmodule

// File: tb/tb_apb_rw_scheduler.sv
// tb/tb_apb_rw_scheduler.sv - directed and randomized self-checking bench for apb_rw_scheduler
module tb_apb_rw_scheduler;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TO_CYC = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic        wr;
  } req_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  apb_rw_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_rw_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=time_limit expected=finish");
    $fatal(1, "watchdog");
  end

  // Transaction-level model: request FIFOs, current transfer, APB phase, last served kind.
  req_t        wq[$];
  req_t        rq[$];
  req_t        m_cur;
  int          m_phase = 0;
  int          m_acc = 0;
  bit          m_last_rd = 1'b1;
  int          m_grant_cyc = 0;
  int          first_grant_cyc = -1;
  int          last_done_cyc = 0;
  int          wait_left = 0;
  int          next_waits = 0;
  bit          b_full_v = 1'b0;
  bit          r_full_v = 1'b0;
  bit          slv_err = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  bit          order[$];
  logic [1:0]  bresp_log[$];
  logic [1:0]  rresp_log[$];
  logic [31:0] rdata_log[$];
  int          lat_log[$];
  int          n_req_w = 0;
  int          n_req_r = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic req_t mkw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_t r;
    r.addr = a; r.data = d; r.strb = s; r.prot = 3'($urandom_range(0, 7)); r.wr = 1'b1;
    return r;
  endfunction

  function automatic req_t mkr(input logic [31:0] a);
    req_t r;
    r.addr = a; r.data = 32'h0; r.strb = 4'h0; r.prot = 3'($urandom_range(0, 7)); r.wr = 1'b0;
    return r;
  endfunction

  task automatic clear_logs();
    order.delete(); bresp_log.delete(); rresp_log.delete(); rdata_log.delete(); lat_log.delete();
    first_grant_cyc = -1;
  endtask

  task automatic drive_heads();
    bus.b_full   = b_full_v;
    bus.r_full   = r_full_v;
    bus.wr_empty = (wq.size() == 0);
    bus.rd_empty = (rq.size() == 0);
    if (wq.size() != 0) begin
      bus.wr_addr = wq[0].addr; bus.wr_data = wq[0].data;
      bus.wr_strb = wq[0].strb; bus.wr_prot = wq[0].prot;
    end else begin
      bus.wr_addr = $urandom; bus.wr_data = $urandom;
    end
    if (rq.size() != 0) begin
      bus.rd_addr = rq[0].addr; bus.rd_prot = rq[0].prot;
    end else begin
      bus.rd_addr = $urandom;
    end
  endtask

  task automatic tick();
    bit fin, abt, free, we, re, ewp, erp, ebp, erq;
    logic [1:0] eresp;
    @(negedge clk);
    cyc++;
    if (bus.psel && !bus.penable) wait_left = next_waits;
    if (bus.psel && bus.penable && wait_left == 0) begin
      bus.pready = 1'b1; bus.pslverr = slv_err; bus.prdata = slv_rdata;
    end else begin
      if (bus.psel && bus.penable) begin
        wait_left--;
        bus.pready = 1'b0;
      end else begin
        bus.pready = 1'($urandom_range(0, 1));
      end
      bus.pslverr = 1'($urandom_range(0, 1));
      bus.prdata  = $urandom;
    end
    drive_heads();
    #1;
    fin = (m_phase == 2) && bus.pready;
    abt = 1'b0;
`ifdef APB_TIMEOUT_EN
    abt = (m_phase == 2) && !bus.pready && (m_acc == TO_CYC - 1);
`endif
    free  = (m_phase == 0) || fin;
    we    = (wq.size() != 0) && !b_full_v;
    re    = (rq.size() != 0) && !r_full_v;
    ewp   = free && we && (!re || m_last_rd);
    erp   = free && re && !ewp;
    ebp   = (fin || abt) && m_cur.wr;
    erq   = (fin || abt) && !m_cur.wr;
    eresp = abt ? 2'b10 : {bus.pslverr, 1'b0};
    chk("wr_pop", 64'(bus.wr_pop), 64'(ewp));
    chk("rd_pop", 64'(bus.rd_pop), 64'(erp));
    chk("b_push", 64'(bus.b_push), 64'(ebp));
    chk("r_push", 64'(bus.r_push), 64'(erq));
    chk("psel", 64'(bus.psel), 64'(m_phase != 0));
    chk("penable", 64'(bus.penable), 64'(m_phase == 2));
    if (m_phase != 0) begin
      chk("paddr", 64'(bus.paddr), 64'(m_cur.addr));
      chk("pwrite", 64'(bus.pwrite), 64'(m_cur.wr));
      chk("pprot", 64'(bus.pprot), 64'(m_cur.prot));
      chk("pstrb", 64'(bus.pstrb), 64'(m_cur.wr ? m_cur.strb : 4'h0));
      if (m_cur.wr) chk("pwdata", 64'(bus.pwdata), 64'(m_cur.data));
    end
    if (ebp) chk("b_resp", 64'(bus.b_resp), 64'(eresp));
    if (erq) begin
      chk("r_resp", 64'(bus.r_resp), 64'(eresp));
      chk("r_data", 64'(bus.r_data), 64'(abt ? 32'h0 : bus.prdata));
    end
    if (bus.b_push) bresp_log.push_back(bus.b_resp);
    if (bus.r_push) begin
      rresp_log.push_back(bus.r_resp);
      rdata_log.push_back(bus.r_data);
    end
    if (fin || abt) begin
      lat_log.push_back(cyc - m_grant_cyc);
      last_done_cyc = cyc;
      m_phase = 0;
    end else if (m_phase == 1) begin
      m_phase = 2;
      m_acc = 0;
    end else if (m_phase == 2) begin
      m_acc++;
    end
    if (ewp) begin
      m_cur = wq.pop_front(); m_last_rd = 1'b0;
    end else if (erp) begin
      m_cur = rq.pop_front(); m_last_rd = 1'b1;
    end
    if (ewp || erp) begin
      m_phase = 1;
      m_grant_cyc = cyc;
      order.push_back(ewp);
      if (first_grant_cyc < 0) first_grant_cyc = cyc;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    bit busy = 1'b1;
    while (busy && n < budget) begin
      tick();
      n++;
      busy = (wq.size() != 0) || (rq.size() != 0) || (m_phase != 0);
    end
    checks++;
    assert (!busy) else begin
      errors++;
      $error("FAIL drain_budget observed=%0d cycles expected=idle within %0d", n, budget);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_empty = 1'b0; bus.rd_empty = 1'b0; bus.b_full = 1'b0; bus.r_full = 1'b0;
    bus.wr_addr = 32'h11; bus.wr_data = 32'h22; bus.wr_strb = 4'hF; bus.wr_prot = 3'h1;
    bus.rd_addr = 32'h33; bus.rd_prot = 3'h2;
    bus.prdata = 32'h0; bus.pready = 1'b1; bus.pslverr = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_psel", 64'(bus.psel), 64'(0));
    chk("rst_penable", 64'(bus.penable), 64'(0));
    chk("rst_pwrite", 64'(bus.pwrite), 64'(0));
    chk("rst_paddr", 64'(bus.paddr), 64'(0));
    chk("rst_pwdata", 64'(bus.pwdata), 64'(0));
    chk("rst_pstrb", 64'(bus.pstrb), 64'(0));
    chk("rst_pprot", 64'(bus.pprot), 64'(0));
    chk("rst_wr_pop", 64'(bus.wr_pop), 64'(0));
    chk("rst_rd_pop", 64'(bus.rd_pop), 64'(0));
    chk("rst_b_push", 64'(bus.b_push), 64'(0));
    chk("rst_r_push", 64'(bus.r_push), 64'(0));
    chk("rst_b_resp", 64'(bus.b_resp), 64'(0));
    chk("rst_r_resp", 64'(bus.r_resp), 64'(0));
    bus.wr_empty = 1'b1; bus.rd_empty = 1'b1;
    @(negedge clk);
    rst = 1'b1;

    // Both kinds pending from reset: W,R,W,R back-to-back, 2 cycles each.
    clear_logs();
    wq.push_back(mkw(32'h100, 32'hA0A0A0A0, 4'hF)); wq.push_back(mkw(32'h104, 32'hB1B1B1B1, 4'h5));
    rq.push_back(mkr(32'h200)); rq.push_back(mkr(32'h204));
    drain(40);
    chk("t3_order_n", 64'(order.size()), 64'(4));
    chk("t3_order", 64'({order.size() > 0 ? order[0] : 1'b0, order.size() > 1 ? order[1] : 1'b1,
                         order.size() > 2 ? order[2] : 1'b0, order.size() > 3 ? order[3] : 1'b1}), 64'(4'b1010));
    chk("t3_span", 64'(last_done_cyc - first_grant_cyc), 64'(8));

    // Single zero-wait write.
    clear_logs();
    wq.push_back(mkw(32'h10, 32'hDEADBEEF, 4'hF));
    drain(20);
    chk("t1_b_count", 64'(bresp_log.size()), 64'(1));
    chk("t1_b_resp", 64'(bresp_log.size() > 0 ? bresp_log[0] : 2'b11), 64'(2'b00));
    chk("t1_latency", 64'(lat_log.size() > 0 ? lat_log[0] : 0), 64'(2));

    // Read with three wait states.
    clear_logs();
    slv_rdata = 32'h1234; next_waits = 3;
    rq.push_back(mkr(32'h20));
    drain(20);
    chk("t2_r_count", 64'(rresp_log.size()), 64'(1));
    chk("t2_r_data", 64'(rdata_log.size() > 0 ? rdata_log[0] : 32'hFFFF_FFFF), 64'(32'h1234));
    chk("t2_r_resp", 64'(rresp_log.size() > 0 ? rresp_log[0] : 2'b11), 64'(2'b00));
    chk("t2_latency", 64'(lat_log.size() > 0 ? lat_log[0] : 0), 64'(5));
    next_waits = 0;

    // B FIFO full holds writes back while reads proceed.
    clear_logs();
    b_full_v = 1'b1;
    wq.push_back(mkw(32'h30, 32'h30303030, 4'hC));
    rq.push_back(mkr(32'h34)); rq.push_back(mkr(32'h38));
    repeat (8) tick();
    chk("t4_reads_only", 64'(order.size()), 64'(2));
    chk("t4_write_held", 64'(wq.size()), 64'(1));
    b_full_v = 1'b0;
    drain(20);
    chk("t4_write_last", 64'(order.size() > 2 ? order[2] : 1'b0), 64'(1));

    // Slave error on a write, clean read afterwards.
    clear_logs();
    slv_err = 1'b1;
    wq.push_back(mkw(32'h44, 32'h44444444, 4'h1));
    drain(20);
    slv_err = 1'b0;
    rq.push_back(mkr(32'h48));
    drain(20);
    chk("t5_b_slverr", 64'(bresp_log.size() > 0 ? bresp_log[0] : 2'b00), 64'(2'b10));
    chk("t5_r_okay", 64'(rresp_log.size() > 0 ? rresp_log[0] : 2'b11), 64'(2'b00));

    // Reset asserted while a read sits in ACCESS.
    next_waits = 6;
    rq.push_back(mkr(32'h60));
    for (int i = 0; i < 10 && m_phase != 2; i++) tick();
    chk("t6_in_access", 64'(m_phase), 64'(2));
    clear_logs();
    wq.push_back(mkw(32'h50, 32'hCAFE0050, 4'h3));
    @(negedge clk);
    drive_heads();
    rst = 1'b0;
    #1;
    chk("t6_psel", 64'(bus.psel), 64'(0));
    chk("t6_penable", 64'(bus.penable), 64'(0));
    chk("t6_r_push", 64'(bus.r_push), 64'(0));
    chk("t6_b_push", 64'(bus.b_push), 64'(0));
    chk("t6_wr_pop", 64'(bus.wr_pop), 64'(0));
    m_phase = 0; m_last_rd = 1'b1;
    @(negedge clk);
    bus.wr_empty = 1'b1; bus.rd_empty = 1'b1;
    rst = 1'b1;
    next_waits = 0;
    drain(20);
    chk("t6_order", 64'(order.size() == 1 ? order[0] : 1'b0), 64'(1));
    chk("t6_no_r", 64'(rresp_log.size()), 64'(0));
    chk("t6_b_count", 64'(bresp_log.size()), 64'(1));

`ifdef APB_TIMEOUT_EN
    clear_logs();
    next_waits = 100;
    rq.push_back(mkr(32'h70));
    drain(30);
    chk("to_r_resp", 64'(rresp_log.size() > 0 ? rresp_log[0] : 2'b00), 64'(2'b10));
    chk("to_r_data", 64'(rdata_log.size() > 0 ? rdata_log[0] : 32'hFFFF_FFFF), 64'(0));
    chk("to_latency", 64'(lat_log.size() > 0 ? lat_log[0] : 0), 64'(TO_CYC + 1));
    next_waits = 0;
`endif

    // Randomized traffic with back-pressure, wait states and slave errors.
    clear_logs();
    n_req_w = 0; n_req_r = 0;
    repeat (400) begin
      if (wq.size() < 4 && $urandom_range(0, 2) == 0) begin
        wq.push_back(mkw($urandom, $urandom, 4'($urandom_range(0, 15))));
        n_req_w++;
      end
      if (rq.size() < 4 && $urandom_range(0, 2) == 0) begin
        rq.push_back(mkr($urandom));
        n_req_r++;
      end
      b_full_v   = ($urandom_range(0, 3) == 0);
      r_full_v   = ($urandom_range(0, 3) == 0);
      next_waits = $urandom_range(0, 3);
      slv_err    = 1'($urandom_range(0, 1));
      slv_rdata  = $urandom;
      tick();
    end
    b_full_v = 1'b0; r_full_v = 1'b0;
    drain(100);
    chk("rnd_b_count", 64'(bresp_log.size()), 64'(n_req_w));
    chk("rnd_r_count", 64'(rresp_log.size()), 64'(n_req_r));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
